// File: rtl/tvm_mem_sched_pkg.sv
// Shared definitions for the VPI memory read scheduler: FSM state encoding and
// a small min helper used for burst sizing.
package tvm_mem_sched_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StStream = 2'd2,
        StDone   = 2'd3
    } sched_state_e;

    // Wide enough for any SIZE_WIDTH in use; callers truncate the result.
    function automatic logic [63:0] min_u(input logic [63:0] a, input logic [63:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/tvm_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo
// NUM_CLIENTS. Produces a one-hot grant, its index, and a valid flag.
module tvm_rr_arbiter #(
    parameter int unsigned NUM_CLIENTS = 2,
    localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IdxW-1:0]        ptr,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic [IdxW-1:0]        gnt_idx,
    output logic                   gnt_valid
);

    int unsigned cand;

    // Scan clients starting at ptr; the first hit wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IdxW'(cand);
            end
        end
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tvm_vpi_mem_read_scheduler.sv
// Shares the host read-control channel of one memory interface among several
// requesters. Round-robin arbitration, splitting into bursts of at most
// MAX_BURST elements, and steering of read_en / read_data_valid to the winner.
module tvm_vpi_mem_read_scheduler
    import tvm_mem_sched_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SIZE_WIDTH  = 32,
    parameter int unsigned MAX_BURST   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            cl_req_valid,
    output logic [NUM_CLIENTS-1:0]            cl_req_ready,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
    input  logic [NUM_CLIENTS*SIZE_WIDTH-1:0] cl_req_size,
    input  logic [NUM_CLIENTS-1:0]            cl_data_ready,
    output logic [NUM_CLIENTS-1:0]            cl_data_valid,
    output logic [NUM_CLIENTS-1:0]            cl_done,
    output logic                              host_read_req,
    output logic [ADDR_WIDTH-1:0]             host_read_addr,
    output logic [SIZE_WIDTH-1:0]             host_read_size,
    output logic                              read_en,
    input  logic                              read_data_valid,
    output logic                              busy
);

    localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    sched_state_e          state_q, state_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
    logic [SIZE_WIDTH-1:0] burst_left_q, burst_left_d;

    logic [NUM_CLIENTS-1:0] arb_gnt;
    logic [IdxW-1:0]        arb_idx;
    logic                   arb_valid;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [SIZE_WIDTH-1:0]  sel_size;
    logic [SIZE_WIDTH-1:0]  burst_size;
    logic                   beat;

    tvm_rr_arbiter #(
        .NUM_CLIENTS(NUM_CLIENTS)
    ) u_arb (
        .req      (cl_req_valid),
        .ptr      (rr_ptr_q),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .gnt_valid(arb_valid)
    );

    assign sel_addr   = cl_req_addr[32'(arb_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_size   = cl_req_size[32'(arb_idx) * SIZE_WIDTH +: SIZE_WIDTH];
    assign burst_size = SIZE_WIDTH'(min_u(64'(remaining_q), 64'(MAX_BURST)));
    assign beat       = read_en & read_data_valid;

    // State and datapath registers; reset drops any in-flight transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            burst_left_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            burst_left_q <= burst_left_d;
        end
    end

    // Next-state and burst bookkeeping.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        burst_left_d = burst_left_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d     = arb_idx;
                    cur_addr_d  = sel_addr;
                    remaining_d = sel_size;
                    state_d     = (sel_size == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                burst_left_d = burst_size;
                state_d      = StStream;
            end
            StStream: begin
                // burst_left_q >= 1 and remaining_q >= burst_left_q here, so no underflow.
                if (beat) begin
                    burst_left_d = burst_left_q - 1'b1;
                    remaining_d  = remaining_q - 1'b1;
                    cur_addr_d   = cur_addr_q + 1'b1;
                    if (burst_left_q == SIZE_WIDTH'(1)) begin
                        state_d = (remaining_q == SIZE_WIDTH'(1)) ? StDone : StIssue;
                    end
                end
            end
            StDone: begin
                rr_ptr_d = (grant_q == IdxW'(NUM_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state; everything idles at zero.
    always_comb begin
        cl_req_ready   = '0;
        cl_data_valid  = '0;
        cl_done        = '0;
        host_read_req  = 1'b0;
        host_read_addr = '0;
        host_read_size = '0;
        read_en        = 1'b0;
        busy           = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                // An accept during reset would be discarded, so do not advertise it.
                if (!rst) begin
                    cl_req_ready = arb_gnt;
                end
            end
            StIssue: begin
                host_read_req  = 1'b1;
                host_read_addr = cur_addr_q;
                host_read_size = burst_size;
            end
            StStream: begin
                read_en                = cl_data_ready[grant_q];
                cl_data_valid[grant_q] = read_data_valid;
            end
            StDone: begin
                cl_done[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
